// File: rtl/unpooling_2x2_if.sv
// Handshake bundle between the pooled-bit source, the unpooling stage and the next serial stage.
// Pure wiring, no latency.
// Input side uses iVALID/oREADY, output side uses oVALID/iREADY; neither side holds state here.
interface unpooling_2x2_if;
    logic iVALID;
    logic iDATA;
    logic oREADY;
    logic oVALID;
    logic oDATA;
    logic iREADY;
    logic oFRAME_DONE;

    // Upstream source and downstream sink as seen from the environment.
    modport master (
        output iVALID,
        output iDATA,
        output iREADY,
        input  oREADY,
        input  oVALID,
        input  oDATA,
        input  oFRAME_DONE
    );

    // The unpooling stage itself.
    modport slave (
        input  iVALID,
        input  iDATA,
        input  iREADY,
        output oREADY,
        output oVALID,
        output oDATA,
        output oFRAME_DONE
    );
endinterface

// File: rtl/unpooling_2x2.sv
// Binary 2x2 nearest-neighbour unpooling: buffers one pooled row, then emits it twice, each bit doubled.
// Latency: first output bit is valid the cycle after the last input bit of a row is accepted.
// Backpressure: input and output phases never overlap; iREADY=0 freezes oDATA/oVALID and all counters.
module unpooling_2x2 #(
    parameter int W_IN = 15,
    parameter int H_IN = 15,
    parameter int CB   = 5,
    parameter int RB   = 4
) (
    input  logic      iCLK,
    input  logic      iRSTn,
    input  logic      iCLR,
    unpooling_2x2_if.slave bus
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        EMIT0 = 2'd1,
        EMIT1 = 2'd2
    } state_t;

    // Terminal counts; wrap is by explicit compare so non-power-of-two sizes work.
    localparam logic [CB-1:0] IN_LAST  = CB'(W_IN - 1);
    localparam logic [CB-1:0] OUT_LAST = CB'(2 * W_IN - 1);
    localparam logic [RB-1:0] ROW_LAST = RB'(H_IN - 1);

    state_t          state;
    state_t          stateNext;
    logic [CB-1:0]   inCol;
    logic [CB-1:0]   outCol;
    logic [RB-1:0]   row;
    logic [W_IN-1:0] lineBuf;

    logic            inFire;
    logic            outFire;
    logic            inLast;
    logic            outLast;
    logic            lbBit;

    // Handshakes depend only on registered state plus the partner's valid/ready,
    // so there is no combinational path from iVALID to oVALID or iREADY to oREADY.
    assign inFire  = (state == LOAD) & bus.iVALID;
    assign outFire = (state != LOAD) & bus.iREADY;
    assign inLast  = (inCol == IN_LAST);
    assign outLast = (outCol == OUT_LAST);

    // State register.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state <= LOAD;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state: fill the row, play it out once per output row, then go back for the next.
    always_comb begin
        stateNext = state;
        if (iCLR) begin
            stateNext = LOAD;
        end else begin
            case (state)
                LOAD: begin
                    if (inFire && inLast) begin
                        stateNext = EMIT0;
                    end
                end
                EMIT0: begin
                    if (outFire && outLast) begin
                        stateNext = EMIT1;
                    end
                end
                EMIT1: begin
                    if (outFire && outLast) begin
                        stateNext = LOAD;
                    end
                end
                default: stateNext = LOAD;
            endcase
        end
    end

    // Input column: advances per accepted bit, wraps at the end of the pooled row.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            inCol <= '0;
        end else if (iCLR) begin
            inCol <= '0;
        end else if (inFire) begin
            inCol <= inLast ? '0 : inCol + 1'b1;
        end
    end

    // Output column: advances per accepted output bit, wraps at twice the row width.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            outCol <= '0;
        end else if (iCLR) begin
            outCol <= '0;
        end else if (outFire) begin
            outCol <= outLast ? '0 : outCol + 1'b1;
        end
    end

    // Row counter: steps when the second copy of a row finishes, wraps at frame end.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            row <= '0;
        end else if (iCLR) begin
            row <= '0;
        end else if ((state == EMIT1) && outFire && outLast) begin
            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end
    end

    // Line buffer write: every entry is rewritten during LOAD before it is read,
    // so it is only zeroed on reset/clear, not between rows.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            lineBuf <= '0;
        end else if (iCLR) begin
            lineBuf <= '0;
        end else if (inFire) begin
            for (int i = 0; i < W_IN; i++) begin
                if (int'(inCol) == i) begin
                    lineBuf[i] <= bus.iDATA;
                end
            end
        end
    end

    // Line buffer read: each stored bit covers two output columns.
    always_comb begin
        lbBit = 1'b0;
        for (int i = 0; i < W_IN; i++) begin
            if (int'(outCol >> 1) == i) begin
                lbBit = lineBuf[i];
            end
        end
    end

    assign bus.oREADY      = (state == LOAD);
    assign bus.oVALID      = (state != LOAD);
    assign bus.oDATA       = (state != LOAD) & lbBit;
    assign bus.oFRAME_DONE = (state == EMIT1) & outLast & (row == ROW_LAST);

endmodule

// File: tb/tb_unpooling_2x2.sv
// Directed bench for unpooling_2x2 with W_IN=4, H_IN=2.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
// Expected output sequences are written out literally, first output bit leftmost.
module tb_unpooling_2x2;

    logic iCLK  = 1'b0;
    logic iRSTn = 1'b0;
    logic iCLR  = 1'b0;

    int testsRun  = 0;
    int testsFail = 0;

    unpooling_2x2_if bus ();

    unpooling_2x2 #(
        .W_IN (4),
        .H_IN (2),
        .CB   (3),
        .RB   (1)
    ) dut (
        .iCLK  (iCLK),
        .iRSTn (iRSTn),
        .iCLR  (iCLR),
        .bus   (bus)
    );

    always #5 iCLK = ~iCLK;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive n input cycles from the vld/dat tables; block must be in LOAD throughout.
    task automatic feedStream(input string tag, input logic [0:7] vld, input logic [0:7] dat,
                              input int n, input bit expectEmit);
        for (int i = 0; i < n; i++) begin
            checkVal({tag, "_rdy"}, 32'(bus.oREADY), 32'd1);
            checkVal({tag, "_novld"}, 32'(bus.oVALID), 32'd0);
            bus.iVALID = vld[i];
            bus.iDATA  = dat[i];
            @(posedge iCLK);
            #1;
        end
        bus.iVALID = 1'b0;
        bus.iDATA  = 1'b0;
        if (expectEmit) begin
            checkVal({tag, "_latency"}, 32'(bus.oVALID), 32'd1);
        end
    endtask

    // Collect nOut output handshakes with iREADY cycling through rdyPat.
    task automatic drain(input string tag, input logic [0:15] exp, input logic [0:3] rdyPat,
                         input int doneIdx, input int nOut);
        int k;
        int cyc;
        k   = 0;
        cyc = 0;
        while (k < nOut && cyc < 200) begin
            bus.iREADY = rdyPat[cyc % 4];
            checkVal({tag, "_vld"}, 32'(bus.oVALID), 32'd1);
            checkVal({tag, "_dat"}, 32'(bus.oDATA), 32'(exp[k]));
            if (bus.iREADY) begin
                checkVal({tag, "_done"}, 32'(bus.oFRAME_DONE), (k == doneIdx) ? 32'd1 : 32'd0);
                k++;
            end
            @(posedge iCLK);
            #1;
            cyc++;
        end
        checkVal({tag, "_count"}, 32'(k), 32'(nOut));
        if (nOut == 16) begin
            bus.iREADY = 1'b0;
            checkVal({tag, "_endrdy"}, 32'(bus.oREADY), 32'd1);
            checkVal({tag, "_endvld"}, 32'(bus.oVALID), 32'd0);
            checkVal({tag, "_enddat"}, 32'(bus.oDATA), 32'd0);
            checkVal({tag, "_enddone"}, 32'(bus.oFRAME_DONE), 32'd0);
        end
    endtask

    initial begin
        bus.iVALID = 1'b0;
        bus.iDATA  = 1'b0;
        bus.iREADY = 1'b0;

        // Reset values
        #2;
        checkVal("rst_rdy", 32'(bus.oREADY), 32'd1);
        checkVal("rst_vld", 32'(bus.oVALID), 32'd0);
        checkVal("rst_dat", 32'(bus.oDATA), 32'd0);
        checkVal("rst_done", 32'(bus.oFRAME_DONE), 32'd0);
        #20;
        iRSTn = 1'b1;
        @(posedge iCLK);
        #1;

        // Basic row 1011 (frame row 0)
        feedStream("basic", 8'b1111_0000, 8'b1011_0000, 4, 1'b1);
        drain("basic", 16'b1100_1111_1100_1111, 4'b1111, -1, 16);

        // Backpressure, same row (frame row 1, so last bit ends the frame)
        feedStream("bp", 8'b1111_0000, 8'b1011_0000, 4, 1'b1);
        drain("bp", 16'b1100_1111_1100_1111, 4'b1001, 15, 16);

        // Frame wrap: 0110 then 1001, then the next frame starts at row 0
        feedStream("wrap0", 8'b1111_0000, 8'b0110_0000, 4, 1'b1);
        drain("wrap0", 16'b0011_1100_0011_1100, 4'b1111, -1, 16);
        feedStream("wrap1", 8'b1111_0000, 8'b1001_0000, 4, 1'b1);
        drain("wrap1", 16'b1100_0011_1100_0011, 4'b1111, 15, 16);
        feedStream("wrap2", 8'b1111_0000, 8'b0110_0000, 4, 1'b1);
        drain("wrap2", 16'b0011_1100_0011_1100, 4'b1111, -1, 16);

        // iCLR on the 5th output bit of EMIT0 (row counter was 1 before the clear)
        feedStream("clr", 8'b1111_0000, 8'b1011_0000, 4, 1'b1);
        drain("clr", 16'b1100_1111_1100_1111, 4'b1111, -1, 4);
        iCLR       = 1'b1;
        bus.iREADY = 1'b1;
        checkVal("clr_pre_dat", 32'(bus.oDATA), 32'd1);
        @(posedge iCLK);
        #1;
        iCLR       = 1'b0;
        bus.iREADY = 1'b0;
        checkVal("clr_vld", 32'(bus.oVALID), 32'd0);
        checkVal("clr_rdy", 32'(bus.oREADY), 32'd1);
        checkVal("clr_dat", 32'(bus.oDATA), 32'd0);
        checkVal("clr_done", 32'(bus.oFRAME_DONE), 32'd0);
        feedStream("clr_r0", 8'b1111_0000, 8'b1111_0000, 4, 1'b1);
        drain("clr_r0", 16'b1111_1111_1111_1111, 4'b1111, -1, 16);
        feedStream("clr_r1", 8'b1111_0000, 8'b0001_0000, 4, 1'b1);
        drain("clr_r1", 16'b0000_0011_0000_0011, 4'b1111, 15, 16);

        // Async reset after 2 input bits, with row counter at 1
        feedStream("ar_pre", 8'b1111_0000, 8'b1111_0000, 4, 1'b1);
        drain("ar_pre", 16'b1111_1111_1111_1111, 4'b1111, -1, 16);
        feedStream("ar_part", 8'b1100_0000, 8'b1100_0000, 2, 1'b0);
        #2;
        iRSTn = 1'b0;
        #1;
        checkVal("ar_rdy", 32'(bus.oREADY), 32'd1);
        checkVal("ar_vld", 32'(bus.oVALID), 32'd0);
        checkVal("ar_dat", 32'(bus.oDATA), 32'd0);
        checkVal("ar_done", 32'(bus.oFRAME_DONE), 32'd0);
        #10;
        iRSTn = 1'b1;
        @(posedge iCLK);
        #1;
        feedStream("ar_row", 8'b1111_0000, 8'b0001_0000, 4, 1'b1);
        drain("ar_row", 16'b0000_0011_0000_0011, 4'b1111, -1, 16);

        // Input gaps: accepted bits form 1001 (frame row 1)
        feedStream("gap", 8'b1001_0110, 8'b1110_1010, 7, 1'b1);
        drain("gap", 16'b1100_0011_1100_0011, 4'b1111, 15, 16);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule

// File: doc/unpooling_2x2.md
# unpooling_2x2

Binary 2×2 nearest-neighbour unpooling (upsampling) stage for the 1-bit CNN datapath. It is the inverse of the 1-bit max-pooling stage. It accepts a serial, row-major stream of pooled activations, one bit per handshake. It emits a stream twice as wide and twice as tall: each input bit is repeated twice horizontally, and each buffered row is repeated twice vertically. It sits on the decoder side of the feature-map pipeline, between a pooled feature source and the next serial convolution stage.

## Interface
- W_IN, 15: input row width in bits (pooled columns).
- H_IN, 15: input rows per frame.
- CB, 5: output column counter width. Must satisfy 2^CB ≥ 2·W_IN.
- RB, 4: row counter width. Must satisfy 2^RB ≥ H_IN.

Ports (clock and reset first):
- iCLK  input  1  system clock. All state updates on the rising edge.
- iRSTn  input  1  reset, asynchronous and active-low.
- iCLR  input  1  synchronous clear. Highest priority after reset.
- iVALID  input  1  upstream has a valid bit on iDATA.
- iDATA  input  1  pooled activation bit.
- oREADY  output  1  block can accept an input bit.
- oVALID  output  1  oDATA holds a valid upsampled bit.
- oDATA  output  1  upsampled activation bit.
- iREADY  input  1  downstream accepts oDATA.
- oFRAME_DONE  output  1  marks the last output bit of a frame.

## Operation
- State machine with three states: LOAD, EMIT0, EMIT1. Reset/clear state is LOAD.
- **LOAD**
  - oREADY=1, oVALID=0.
  - An input handshake occurs on (iVALID & oREADY). Each handshake writes iDATA into line buffer LB[in_col] and increments in_col (0..W_IN-1).
  - On the handshake with in_col=W_IN-1: in_col←0, state→EMIT0.
  - The first bit accepted in a row is column 0.
- **EMIT0 / EMIT1**
  - oREADY=0, oVALID=1, oDATA=LB[out_col>>1].
  - An output handshake occurs on (oVALID & iREADY). Each handshake increments out_col (0..2·W_IN-1).
  - At out_col=2·W_IN-1: out_col←0. EMIT0 goes to EMIT1. EMIT1 goes to LOAD and increments row.
- **Row counter**
  - row increments on leaving EMIT1.
  - When row=H_IN-1 it wraps to 0 instead.
- **oFRAME_DONE**
  - = oVALID & state==EMIT1 & out_col==2·W_IN-1 & row==H_IN-1.
  - Purely a decode of registered state. Handshake-qualified by downstream using iREADY.
- **Idle outputs**
  - oDATA=0 whenever oVALID=0.
  - LB is not cleared between rows; every LB entry is overwritten in LOAD before it is used.
- **iCLR**
  - Forces state=LOAD and in_col=out_col=row=0, and clears LB to 0.
  - Overrides any handshake in the same cycle; the input bit offered on that cycle is not accepted.
- **Reset mid-operation**
  - Same effect as iCLR, applied asynchronously. Partial rows and frames are discarded.
  - No output bit is produced for a row until all W_IN input bits have been accepted.
- **Throughput and handshake direction**
  - Input and output phases never overlap.
  - Per row: W_IN input cycles plus 4·W_IN output cycles at full rate.
  - No combinational path from iVALID to oVALID or from iREADY to oREADY.

## Timing
- Reset values: oREADY=1, oVALID=0, oDATA=0, oFRAME_DONE=0.
- Latency: last input bit of a row accepted at edge k gives oVALID=1 with oDATA=LB[0] in the cycle after edge k. There are zero bubble cycles.
- Downstream stall: with iREADY=0, oDATA, oVALID and all counters hold indefinitely.
- Upstream gap: iVALID=0 in LOAD holds in_col; there is no timeout.
- EMIT1→LOAD: oREADY=1 in the cycle after the final output handshake.
- Counter widths: in_col uses CB bits, out_col uses CB bits, row uses RB bits. Wrap is by explicit compare, not natural overflow.

## Test plan
All scenarios use W_IN=4, H_IN=2.
- **Basic row**: reset, then feed 1,0,1,1 with iVALID=1 and iREADY=1.
  - oVALID rises the cycle after the 4th accept.
  - oDATA sequence is 1,1,0,0,1,1,1,1 and then that sequence again (16 bits).
  - oREADY returns to 1 the next cycle.
- **Backpressure**: same row, with iREADY toggled 1,0,0,1 repeatedly.
  - Output sequence identical to the basic-row case; no bit duplicated or dropped.
  - oDATA is stable while iREADY=0.
- **Frame wrap**: rows 0110 then 1001.
  - oFRAME_DONE is high only on the 32nd output bit (value 1).
  - row returns to 0, and the next frame's first row reproduces its expected pattern.
- **iCLR mid-emit**: assert iCLR at the 5th output bit of EMIT0.
  - Next cycle: oVALID=0, oREADY=1, oDATA=0.
  - A subsequent row 1111 emits sixteen 1s, and oFRAME_DONE stays 0 until row 1 completes.
- **Async reset mid-load**: drop iRSTn after 2 input bits.
  - Outputs take reset values immediately.
  - After release, the row 0001 emits 0,0,0,0,0,0,1,1 twice.
- **Input gaps**: iVALID pattern 1,0,0,1,0,1,1 carrying bits 1,x,x,0,x,0,1.
  - Accepted row is 1001, so the output is 11000011 twice.
  - oVALID never asserts before the 4th accepted bit.
